inpkt_dispatch: RTL and testbench

INPKT_DISPATCH -- requirements
Module: inpkt_dispatch

---
 rtl/inpkt_dispatch_pkg.sv | 14 +
 rtl/inpkt_dispatch_rr_arbiter.sv | 32 +++
 rtl/inpkt_dispatch.sv | 117 +++++++++++
 tb/tb_inpkt_dispatch.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/inpkt_dispatch_pkg.sv
// Shared definitions for the input packet dispatcher: FSM encoding and header geometry.
package inpkt_dispatch_pkg;

    typedef enum logic [1:0] {
        HDR_LO = 2'd0,
        HDR_HI = 2'd1,
        SELECT = 2'd2,
        DATA   = 2'd3
    } state_t;

    localparam int HDR_BYTES     = 2;
    localparam int LEN_W_DEFAULT = 16;

endpackage

// File: rtl/inpkt_dispatch_rr_arbiter.sv
// Combinational round-robin picker: first requester strictly after last_grant, wrapping.
module rr_arbiter
    import inpkt_dispatch_pkg::*;
#(
    parameter int N_UNITS = 4,
    parameter int SEL_W   = 2
) (
    input  logic [N_UNITS-1:0] req,
    input  logic [SEL_W-1:0]   last_grant,
    output logic [N_UNITS-1:0] grant,
    output logic               valid
);

    int               idx;
    logic [SEL_W-1:0] idx_s;

    always_comb begin
        grant = '0;
        valid = 1'b0;
        idx   = 0;
        idx_s = '0;
        for (int k = 1; k <= N_UNITS; k++) begin
            idx   = (int'(last_grant) + k) % N_UNITS;
            idx_s = SEL_W'(idx);
            if (!valid && req[idx_s]) begin
                grant[idx_s] = 1'b1;
                valid        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/inpkt_dispatch.sv
// Parses length-prefixed packets from a FWFT FIFO and streams each payload to one
// round-robin-selected idle unit.
module inpkt_dispatch
    import inpkt_dispatch_pkg::*;
#(
    parameter int N_UNITS = 4,
    parameter int LEN_W   = LEN_W_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         fifo_dout,
    input  logic               fifo_empty,
    output logic               fifo_rd_en,
    input  logic [N_UNITS-1:0] unit_idle,
    input  logic [N_UNITS-1:0] unit_full,
    output logic [N_UNITS-1:0] unit_wr_en,
    output logic [7:0]         unit_dout,
    output logic               unit_first,
    output logic               unit_last,
    output logic               busy,
    output logic [15:0]        pkt_count
);

    localparam int SEL_W = (N_UNITS > 1) ? $clog2(N_UNITS) : 1;

    state_t             state;
    logic [LEN_W-1:0]   len;
    logic [LEN_W-1:0]   remaining;
    logic [LEN_W-1:0]   len_hdr;
    logic [SEL_W-1:0]   sel;
    logic [SEL_W-1:0]   last_grant;
    logic [SEL_W-1:0]   grant_idx;
    logic [N_UNITS-1:0] grant;
    logic               grant_vld;
    logic               first_pend;
    logic [15:0]        pkt_count_r;
    logic               hdr_pop;
    logic               xfer;

    rr_arbiter #(
        .N_UNITS (N_UNITS),
        .SEL_W   (SEL_W)
    ) u_arb (
        .req        (unit_idle),
        .last_grant (last_grant),
        .grant      (grant),
        .valid      (grant_vld)
    );

    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < N_UNITS; i++) begin
            if (grant[i]) grant_idx = SEL_W'(i);
        end
    end

    // Full header value as it will be latched on the high-byte pop.
    assign len_hdr = LEN_W'({fifo_dout, len[7:0]});

    assign hdr_pop    = ~rst & ~fifo_empty & ((state == HDR_LO) | (state == HDR_HI));
    assign xfer       = ~rst & (state == DATA) & ~fifo_empty & ~unit_full[sel];
    assign fifo_rd_en = hdr_pop | xfer;
    assign unit_wr_en = xfer ? (N_UNITS'(1) << sel) : '0;
    assign unit_dout  = fifo_dout;
    assign unit_first = xfer & first_pend;
    assign unit_last  = xfer & (remaining == LEN_W'(1));
    assign busy       = ~rst & (state != HDR_LO);
    assign pkt_count  = pkt_count_r;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= HDR_LO;
            len         <= '0;
            remaining   <= '0;
            sel         <= '0;
            last_grant  <= SEL_W'(N_UNITS - 1);
            first_pend  <= 1'b0;
            pkt_count_r <= '0;
        end else begin
            case (state)
                HDR_LO: begin
                    if (hdr_pop) begin
                        len   <= LEN_W'(fifo_dout);
                        state <= HDR_HI;
                    end
                end
                HDR_HI: begin
                    if (hdr_pop) begin
                        len   <= len_hdr;
                        state <= (len_hdr == '0) ? HDR_LO : SELECT;
                    end
                end
                SELECT: begin
                    if (grant_vld) begin
                        sel        <= grant_idx;
                        last_grant <= grant_idx;
                        remaining  <= len;
                        first_pend <= 1'b1;
                        state      <= DATA;
                    end
                end
                DATA: begin
                    if (xfer) begin
                        remaining  <= remaining - LEN_W'(1);
                        first_pend <= 1'b0;
                        if (remaining == LEN_W'(1)) begin
                            pkt_count_r <= pkt_count_r + 16'd1;
                            state       <= HDR_LO;
                        end
                    end
                end
                default: state <= HDR_LO;
            endcase
        end
    end

endmodule

// File: tb/tb_inpkt_dispatch.sv
// Directed bench for inpkt_dispatch: byte-level scoreboard of expected strobes plus literal pins.
module tb_inpkt_dispatch;

    localparam int N  = 4;
    localparam int LW = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic [7:0]   fifo_dout;
    logic         fifo_empty;
    logic         fifo_rd_en;
    logic [N-1:0] unit_idle;
    logic [N-1:0] unit_full;
    logic [N-1:0] unit_wr_en;
    logic [7:0]   unit_dout;
    logic         unit_first;
    logic         unit_last;
    logic         busy;
    logic [15:0]  pkt_count;

    always #5 clk = ~clk;

    inpkt_dispatch #(.N_UNITS(N), .LEN_W(LW)) dut (
        .clk        (clk),
        .rst        (rst),
        .fifo_dout  (fifo_dout),
        .fifo_empty (fifo_empty),
        .fifo_rd_en (fifo_rd_en),
        .unit_idle  (unit_idle),
        .unit_full  (unit_full),
        .unit_wr_en (unit_wr_en),
        .unit_dout  (unit_dout),
        .unit_first (unit_first),
        .unit_last  (unit_last),
        .busy       (busy),
        .pkt_count  (pkt_count)
    );

    typedef struct {
        int         unit;
        logic [7:0] b;
        bit         first;
        bit         last;
    } exp_t;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] fq[$];
    exp_t       eq[$];
    exp_t       e;
    int         seen_units[$];
    int         strobes    = 0;
    int         m_ptr      = N - 1;
    int         m_count    = 0;
    int         pop_cnt    = 0;
    bit         gap_mode   = 1'b0;
    bit         full_mode  = 1'b0;
    bit         data_phase = 1'b0;
    bit         rd_s       = 1'b0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int rr_pick(input logic [N-1:0] mask);
        for (int k = 1; k <= N; k++) begin
            if (mask[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_pkt(input int len, input logic [7:0] seed, input logic [N-1:0] idle_at_grant);
        int u;
        fq.push_back(8'(len));
        fq.push_back(8'(len >> 8));
        if (len > 0) begin
            u     = rr_pick(idle_at_grant);
            m_ptr = u;
            for (int i = 0; i < len; i++) begin
                fq.push_back(seed + 8'(8'h11 * i));
                eq.push_back('{u, seed + 8'(8'h11 * i), (i == 0), (i == len - 1)});
            end
        end
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        eq.delete();
        fq.delete();
        seen_units.delete();
        strobes    = 0;
        m_ptr      = N - 1;
        m_count    = 0;
        data_phase = 1'b0;
        tick(2);
        check("reset_pkt_count", pkt_count, 0);
        check("reset_busy", busy, 0);
        rst = 1'b0;
        tick(1);
    endtask

    task automatic wait_done(input string nm, input int budget);
        int c = 0;
        while ((eq.size() != 0 || fq.size() != 0 || busy) && c < budget) begin
            tick(1);
            c++;
        end
        check({nm, "_timeout"}, (c < budget), 1);
    endtask

    // FIFO model: pops on the edge after a sampled read, optional empty gaps and full noise.
    initial begin
        fifo_empty = 1'b1;
        fifo_dout  = 8'h00;
        unit_full  = '0;
        forever begin
            @(posedge clk);
            #1;
            if (rd_s && fq.size() > 0) begin
                void'(fq.pop_front());
                pop_cnt++;
            end
            fifo_empty = (fq.size() == 0) || (gap_mode && $urandom_range(0, 2) == 0);
            fifo_dout  = (fq.size() > 0) ? fq[0] : 8'h00;
            unit_full  = full_mode ? N'($urandom_range(0, 15)) : '0;
        end
    end

    initial begin
        int u;
        forever begin
            @(negedge clk);
            rd_s = fifo_rd_en;
            if (rst) begin
                check("rst_outputs", {fifo_rd_en, unit_wr_en, unit_first, unit_last, busy}, 0);
                check("rst_pkt_count", pkt_count, 0);
            end else begin
                check("dout_passthru", unit_dout, fifo_dout);
                check("pkt_count", pkt_count, m_count);
                if (data_phase && eq.size() > 0 && unit_full[eq[0].unit])
                    check("rd_while_full", fifo_rd_en, 0);
                if (unit_wr_en != '0) begin
                    u = -1;
                    for (int i = 0; i < N; i++) if (unit_wr_en[i]) u = i;
                    seen_units.push_back(u);
                    strobes++;
                    if (eq.size() == 0) begin
                        check("unexpected_strobe", unit_wr_en, 0);
                    end else begin
                        e = eq.pop_front();
                        check("strobe_unit", unit_wr_en, 64'(1) << e.unit);
                        check("strobe_byte", unit_dout, e.b);
                        check("strobe_first", unit_first, e.first);
                        check("strobe_last", unit_last, e.last);
                        check("strobe_pops", fifo_rd_en, 1);
                        if (e.last) m_count++;
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_rr[5]  = '{0, 1, 2, 3, 0};
        int exp_idl[3] = '{2, 2, 3};
        int start;
        int c;
        rst       = 1'b1;
        unit_idle = '1;
        tick(1);
        do_reset();

        // Single 3-byte packet to unit 0.
        send_pkt(3, 8'hAA, 4'hF);
        wait_done("basic", 100);
        check("basic_strobes", strobes, 3);
        for (int i = 0; i < 3 && i < seen_units.size(); i++) check("basic_unit", seen_units[i], 0);
        check("basic_pkt_count", pkt_count, 1);

        // Five one-byte packets rotate across units.
        do_reset();
        for (int i = 0; i < 5; i++) send_pkt(1, 8'h10 + 8'(i), 4'hF);
        wait_done("rr", 200);
        check("rr_len", seen_units.size(), 5);
        for (int i = 0; i < 5 && i < seen_units.size(); i++) check("rr_grant", seen_units[i], exp_rr[i]);
        check("rr_pkt_count", pkt_count, 5);

        // No idle unit: selection stalls until unit 2 frees up.
        do_reset();
        unit_idle = 4'b0000;
        send_pkt(2, 8'h50, 4'b0100);
        tick(4);
        for (int i = 0; i < 10; i++) begin
            check("stall_rd_en", fifo_rd_en, 0);
            check("stall_wr_en", unit_wr_en, 0);
            check("stall_busy", busy, 1);
            tick(1);
        end
        unit_idle = 4'b0100;
        wait_done("stall", 100);
        unit_idle = 4'hF;
        send_pkt(1, 8'h60, 4'hF);
        wait_done("stall_next", 100);
        check("stall_len", seen_units.size(), 3);
        for (int i = 0; i < 3 && i < seen_units.size(); i++) check("stall_grant", seen_units[i], exp_idl[i]);

        // Zero-length packet is skipped without consuming a grant.
        do_reset();
        send_pkt(0, 8'h00, 4'hF);
        send_pkt(2, 8'h70, 4'hF);
        wait_done("zero", 100);
        check("zero_strobes", strobes, 2);
        for (int i = 0; i < 2 && i < seen_units.size(); i++) check("zero_unit", seen_units[i], 0);
        check("zero_pkt_count", pkt_count, 1);

        // Eight bytes through random empty gaps and full backpressure.
        do_reset();
        start = pop_cnt;
        send_pkt(8, 8'h01, 4'hF);
        c = 0;
        while (pop_cnt - start < 2 && c < 50) begin
            tick(1);
            c++;
        end
        check("bp_hdr_timeout", (c < 50), 1);
        gap_mode   = 1'b1;
        full_mode  = 1'b1;
        data_phase = 1'b1;
        wait_done("bp", 600);
        gap_mode   = 1'b0;
        full_mode  = 1'b0;
        data_phase = 1'b0;
        tick(1);
        check("bp_strobes", strobes, 8);
        check("bp_pkt_count", pkt_count, 1);

        // Reset in the middle of a 5-byte payload, then a clean 4-byte packet.
        do_reset();
        fq.push_back(8'h05);
        fq.push_back(8'h00);
        fq.push_back(8'hA0);
        fq.push_back(8'hA1);
        eq.push_back('{0, 8'hA0, 1'b1, 1'b0});
        eq.push_back('{0, 8'hA1, 1'b0, 1'b0});
        m_ptr = 0;
        c = 0;
        while (strobes < 2 && c < 50) begin
            tick(1);
            c++;
        end
        check("abort_timeout", (c < 50), 1);
        tick(2);
        check("abort_busy_before", busy, 1);
        rst = 1'b1;
        #1;
        check("abort_outputs", {fifo_rd_en, unit_wr_en, unit_first, unit_last, busy}, 0);
        check("abort_pkt_count", pkt_count, 0);
        do_reset();
        send_pkt(4, 8'hC0, 4'hF);
        wait_done("after_abort", 100);
        check("after_abort_strobes", strobes, 4);
        for (int i = 0; i < 4 && i < seen_units.size(); i++) check("after_abort_unit", seen_units[i], 0);
        check("after_abort_pkt_count", pkt_count, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
